sr_latch_bank: RTL

//  Parametrised, clocked bank of WIDTH independent set/reset storage cells.

---
 rtl/sr_latch_bank_if.sv | 26 ++
 rtl/sr_latch_bank.sv | 98 +++++++++
 2 files changed

// File: rtl/sr_latch_bank_if.sv
// Bundle of the sample controls (en/s/r) and registered status outputs of sr_latch_bank.
// set_cnt width tracks WIDTH so it can hold 0..WIDTH without wrap.
interface sr_latch_bank_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] rise;
   logic             any_set;
   logic [CW-1:0]    set_cnt;

   modport master (
      output en, s, r,
      input  q, qn, rise, any_set, set_cnt
   );

   modport slave (
      input  en, s, r,
      output q, qn, rise, any_set, set_cnt
   );
endinterface

// File: rtl/sr_latch_bank.sv
// Clocked bank of WIDTH independent set/reset cells with a selectable s=r=1 resolution,
// registered rising-edge pulses and a population count that always matches q.
module sr_latch_bank #(
   parameter int WIDTH = 8,
   parameter int MODE  = 0
) (
   input logic              clk,
   input logic              clr,
   sr_latch_bank_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);
   // Out-of-range MODE values fall back to the legacy force-low behaviour.
   localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] qn_reg;
   logic [WIDTH-1:0] rise_reg;
   logic             any_reg;
   logic [CW-1:0]    cnt_reg;

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] qn_next;

   function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   always_comb begin
      q_next  = q_reg;
      qn_next = qn_reg;
      for (int i = 0; i < WIDTH; i++) begin
         case ({bus.s[i], bus.r[i]})
            2'b10: begin
               q_next[i]  = 1'b1;
               qn_next[i] = 1'b0;
            end
            2'b01: begin
               q_next[i]  = 1'b0;
               qn_next[i] = 1'b1;
            end
            2'b11: begin
               case (MODE_EFF)
                  1: begin
                     q_next[i]  = 1'b1;
                     qn_next[i] = 1'b0;
                  end
                  2: begin
                     q_next[i]  = 1'b0;
                     qn_next[i] = 1'b1;
                  end
                  // Toggle keys off q only, so the 0/0 state toggles to 1/0.
                  3: begin
                     q_next[i]  = ~q_reg[i];
                     qn_next[i] = q_reg[i];
                  end
                  default: begin
                     q_next[i]  = 1'b0;
                     qn_next[i] = 1'b0;
                  end
               endcase
            end
            default: begin
               q_next[i]  = q_reg[i];
               qn_next[i] = qn_reg[i];
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q_reg    <= '0;
         qn_reg   <= '0;
         rise_reg <= '0;
         any_reg  <= 1'b0;
         cnt_reg  <= '0;
      end else if (bus.en) begin
         q_reg    <= q_next;
         qn_reg   <= qn_next;
         rise_reg <= ~q_reg & q_next;
         any_reg  <= |q_next;
         cnt_reg  <= popcount(q_next);
      end else begin
         rise_reg <= '0;
      end
   end

   assign bus.q       = q_reg;
   assign bus.qn      = qn_reg;
   assign bus.rise    = rise_reg;
   assign bus.any_set = any_reg;
   assign bus.set_cnt = cnt_reg;
endmodule
